// File: rtl/doled_spi_tx_if.sv
// Handshake and frame-content bundle between the string sender FSM and the SPI transmitter.
// The master side supplies frame type, colour bytes and start; the slave side returns busy.
interface doled_spi_tx_if;
    logic [1:0] type_input;
    logic [7:0] blue_input;
    logic [7:0] green_input;
    logic [7:0] red_input;
    logic       doled_start;
    logic       doled_busy;

    modport master (
        output type_input,
        output blue_input,
        output green_input,
        output red_input,
        output doled_start,
        input  doled_busy
    );

    modport slave (
        input  type_input,
        input  blue_input,
        input  green_input,
        input  red_input,
        input  doled_start,
        output doled_busy
    );
endinterface

// File: rtl/doled_spi_tx.sv
// Serialises one 32-bit APA102-style frame per accepted start onto mosi/sck, MSB first.
//  state    | meaning
//  IDLE     | waiting for an armed start; sck=0, mosi=0
//  SHIFT_LO | sck low for SCK_DIV cycles, mosi holds the current bit
//  SHIFT_HI | sck high for SCK_DIV cycles; next bit or frame end on the last one
module doled_spi_tx #(
    parameter int         SCK_DIV    = 1,
    parameter logic [4:0] BRIGHTNESS = 5'h1F,
    parameter bit         END_FILL   = 1'b1
) (
    input  logic            doled_clk,
    input  logic            doled_rst_n,
    doled_spi_tx_if.slave   bus,
    output logic            mosi,
    output logic            sck
);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI} state_t;

    localparam logic [7:0] PHASE_LAST = 8'(SCK_DIV - 1);

    state_t      state;
    logic        armed;
    logic        busy;
    logic [31:0] shreg;
    logic [4:0]  bit_cnt;
    logic [7:0]  phase_cnt;
    logic [31:0] frame;

    always_comb begin
        frame = '0;
        case (bus.type_input)
            2'd0:    frame = '0;
            2'd1:    frame = {3'b111, BRIGHTNESS, bus.blue_input, bus.green_input, bus.red_input};
            default: frame = {32{END_FILL}};
        endcase
    end

    // mosi is taken straight from the shift register MSB, so it is a flop output
    // and only moves when the register loads or shifts.
    assign mosi           = shreg[31];
    assign bus.doled_busy = busy;

    always_ff @(posedge doled_clk or negedge doled_rst_n) begin
        if (!doled_rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            busy      <= 1'b0;
            shreg     <= '0;
            sck       <= 1'b0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
        end else begin
            // A start that stays high is only honoured again after it drops.
            if (!bus.doled_start) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.doled_start && armed) begin
                        armed     <= 1'b0;
                        busy      <= 1'b1;
                        shreg     <= frame;
                        sck       <= 1'b0;
                        bit_cnt   <= 5'd31;
                        phase_cnt <= '0;
                        state     <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase_cnt == PHASE_LAST) begin
                        sck       <= 1'b1;
                        phase_cnt <= '0;
                        state     <= SHIFT_HI;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (phase_cnt == PHASE_LAST) begin
                        sck       <= 1'b0;
                        phase_cnt <= '0;
                        if (bit_cnt != 5'd0) begin
                            shreg   <= {shreg[30:0], 1'b0};
                            bit_cnt <= bit_cnt - 5'd1;
                            state   <= SHIFT_LO;
                        end else begin
                            busy  <= 1'b0;
                            shreg <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_doled_spi_tx.sv
// Bench for doled_spi_tx: random frames checked against a frame-level model,
// with one instance at SCK_DIV=1 and one at SCK_DIV=3.
module tb_doled_spi_tx;

    logic clk = 1'b0;
    logic rst_n;
    logic mosi1, sck1, mosi3, sck3;

    always #5 clk = ~clk;

    doled_spi_tx_if if1();
    doled_spi_tx_if if3();

    doled_spi_tx #(.SCK_DIV(1)) u_dut1 (
        .doled_clk(clk), .doled_rst_n(rst_n), .bus(if1), .mosi(mosi1), .sck(sck1));
    doled_spi_tx #(.SCK_DIV(3)) u_dut3 (
        .doled_clk(clk), .doled_rst_n(rst_n), .bus(if3), .mosi(mosi3), .sck(sck3));

    int checks   = 0;
    int failures = 0;

    // Bits captured on each rising sck, plus mosi-stability and phase-length monitors.
    logic q1[$];
    logic q3[$];
    logic prev_sck1 = 0, prev_mosi1 = 0;
    logic prev_sck3 = 0, prev_mosi3 = 0, prev_busy3 = 0;
    int   viol1 = 0, viol3 = 0, run3 = 0, badrun3 = 0;

    always @(negedge clk) begin
        if (sck1 && !prev_sck1) q1.push_back(mosi1);
        if (sck1 && prev_sck1 && mosi1 !== prev_mosi1) viol1++;
        prev_sck1  = sck1;
        prev_mosi1 = mosi1;
    end

    always @(negedge clk) begin
        if (sck3 && !prev_sck3) q3.push_back(mosi3);
        if (sck3 && prev_sck3 && mosi3 !== prev_mosi3) viol3++;
        if (if3.doled_busy) begin
            if (prev_busy3 && sck3 == prev_sck3) run3++;
            else begin
                if (prev_busy3 && run3 != 3) badrun3++;
                run3 = 1;
            end
        end else if (prev_busy3 && run3 != 3) begin
            badrun3++;
        end
        prev_sck3  = sck3;
        prev_mosi3 = mosi3;
        prev_busy3 = if3.doled_busy;
    end

    function automatic logic [31:0] model_frame(logic [1:0] t, logic [7:0] b, logic [7:0] g, logic [7:0] r);
        if (t == 2'd0) return 32'h0000_0000;
        if (t == 2'd1) return {3'b111, 5'h1F, b, g, r};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pack_bits(input logic q[$]);
        logic [31:0] w = '0;
        foreach (q[i]) w = {w[30:0], q[i]};
        return w;
    endfunction

    // One full frame on the SCK_DIV=1 instance with an upstream-style handshake.
    task automatic run_frame1(input logic [1:0] t, input logic [7:0] b, input logic [7:0] g,
                              input logic [7:0] r, output logic [31:0] word, output int busy_cyc,
                              output int edges, output int rise_lat, output bit tmo);
        tmo = 0; busy_cyc = 0; rise_lat = 0;
        q1.delete();
        @(negedge clk);
        if1.type_input = t; if1.blue_input = b; if1.green_input = g; if1.red_input = r;
        if1.doled_start = 1'b1;
        while (!if1.doled_busy && rise_lat < 20) begin
            @(negedge clk);
            rise_lat++;
        end
        if (!if1.doled_busy) tmo = 1;
        else begin
            if1.doled_start = 1'b0;
            if1.type_input  = 2'($urandom);
            if1.blue_input  = 8'($urandom);
            if1.green_input = 8'($urandom);
            if1.red_input   = 8'($urandom);
            while (if1.doled_busy && busy_cyc < 2000) begin
                busy_cyc++;
                @(negedge clk);
            end
            if (if1.doled_busy) tmo = 1;
        end
        if1.doled_start = 1'b0;
        edges = q1.size();
        word  = pack_bits(q1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (if1.doled_busy !== 1'b0) begin failures++; $display("FAIL reset_busy1 got %b want 0", if1.doled_busy); end
        if (sck1 !== 1'b0)           begin failures++; $display("FAIL reset_sck1 got %b want 0", sck1); end
        if (mosi1 !== 1'b0)          begin failures++; $display("FAIL reset_mosi1 got %b want 0", mosi1); end
        if (if3.doled_busy !== 1'b0) begin failures++; $display("FAIL reset_busy3 got %b want 0", if3.doled_busy); end
        if (sck3 !== 1'b0)           begin failures++; $display("FAIL reset_sck3 got %b want 0", sck3); end
        if (mosi3 !== 1'b0)          begin failures++; $display("FAIL reset_mosi3 got %b want 0", mosi3); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (if1.doled_busy !== 1'b0 || sck1 !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset got busy=%b sck=%b want 0/0", if1.doled_busy, sck1);
        end
    endtask

    task automatic test_led_basic;
        logic [31:0] word; int bc, ed, rl; bit tmo;
        run_frame1(2'd1, 8'h3F, 8'h00, 8'h12, word, bc, ed, rl, tmo);
        checks += 6;
        if (tmo)              begin failures++; $display("FAIL led_basic_timeout got timeout want completion"); end
        if (rl != 1)          begin failures++; $display("FAIL led_basic_accept_latency got %0d want 1", rl); end
        if (word !== 32'hFF3F0012) begin failures++; $display("FAIL led_basic_bits got %h want ff3f0012", word); end
        if (bc != 64)         begin failures++; $display("FAIL led_basic_busy_cycles got %0d want 64", bc); end
        if (ed != 32)         begin failures++; $display("FAIL led_basic_edges got %0d want 32", ed); end
        if (mosi1 !== 1'b0)   begin failures++; $display("FAIL led_basic_mosi_after got %b want 0", mosi1); end
    endtask

    task automatic test_start_end;
        logic [31:0] word; int bc, ed, rl; bit tmo;
        logic [1:0] types [3] = '{2'd0, 2'd2, 2'd3};
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b, g, r;
            b = 8'($urandom); g = 8'($urandom); r = 8'($urandom);
            run_frame1(types[i], b, g, r, word, bc, ed, rl, tmo);
            checks += 3;
            if (tmo) begin failures++; $display("FAIL start_end_timeout type=%0d got timeout want completion", types[i]); end
            if (word !== model_frame(types[i], b, g, r)) begin
                failures++; $display("FAIL start_end_bits type=%0d got %h want %h", types[i], word, model_frame(types[i], b, g, r));
            end
            if (ed != 32) begin failures++; $display("FAIL start_end_edges type=%0d got %0d want 32", types[i], ed); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] word; int bc, ed, rl; bit tmo;
        int total = 0;
        viol1 = 0;
        for (int i = 0; i < 46; i++) begin
            logic [7:0] b, g, r;
            b = 8'($urandom); g = 8'($urandom); r = 8'($urandom);
            run_frame1(2'd1, b, g, r, word, bc, ed, rl, tmo);
            total += ed;
            checks++;
            if (tmo || word !== model_frame(2'd1, b, g, r)) begin
                failures++; $display("FAIL b2b_frame%0d got %h want %h (timeout=%0d)", i, word, model_frame(2'd1, b, g, r), tmo);
            end
        end
        checks += 2;
        if (total != 46 * 32) begin failures++; $display("FAIL b2b_total_bits got %0d want %0d", total, 46 * 32); end
        if (viol1 != 0)       begin failures++; $display("FAIL b2b_mosi_stable got %0d changes want 0", viol1); end
    endtask

    task automatic test_start_during_busy;
        logic [7:0] b, g, r;
        int n = 0, gap = 0;
        b = 8'($urandom); g = 8'($urandom); r = 8'($urandom);
        q1.delete();
        @(negedge clk);
        if1.type_input = 2'd1; if1.blue_input = b; if1.green_input = g; if1.red_input = r;
        if1.doled_start = 1'b1;
        while (!if1.doled_busy && n < 20) begin @(negedge clk); n++; end
        if1.doled_start = 1'b0;
        repeat (5) @(negedge clk);
        if1.doled_start = 1'b1;
        n = 0;
        while (if1.doled_busy && n < 200) begin @(negedge clk); n++; end
        while (!if1.doled_busy && gap < 20) begin @(negedge clk); gap++; end
        if1.doled_start = 1'b0;
        n = 0;
        while (if1.doled_busy && n < 200) begin @(negedge clk); n++; end
        checks += 3;
        if (gap != 1) begin failures++; $display("FAIL pending_start_gap got %0d want 1", gap); end
        if (q1.size() != 64) begin failures++; $display("FAIL pending_start_bits got %0d want 64", q1.size()); end
        else begin
            logic q_a[$], q_b[$];
            q_a = q1[0:31]; q_b = q1[32:63];
            if (pack_bits(q_a) !== model_frame(2'd1, b, g, r) || pack_bits(q_b) !== model_frame(2'd1, b, g, r)) begin
                failures++; $display("FAIL pending_start_frames got %h/%h want %h", pack_bits(q_a), pack_bits(q_b), model_frame(2'd1, b, g, r));
            end
        end
    endtask

    task automatic test_held_start;
        int rises = 0, n = 0;
        logic pb = 0;
        q1.delete();
        @(negedge clk);
        if1.type_input = 2'd1; if1.blue_input = 8'h5A; if1.green_input = 8'hA5; if1.red_input = 8'h3C;
        if1.doled_start = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (if1.doled_busy && !pb) rises++;
            pb = if1.doled_busy;
        end
        checks += 3;
        if (rises != 1)       begin failures++; $display("FAIL held_start_frames got %0d want 1", rises); end
        if (q1.size() != 32)  begin failures++; $display("FAIL held_start_bits got %0d want 32", q1.size()); end
        if1.doled_start = 1'b0;
        @(negedge clk);
        if1.doled_start = 1'b1;
        while (!if1.doled_busy && n < 20) begin @(negedge clk); n++; end
        if (!if1.doled_busy) begin failures++; $display("FAIL held_start_rearm got busy=0 want 1"); end
        if1.doled_start = 1'b0;
        n = 0;
        while (if1.doled_busy && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic test_div3;
        logic [7:0] b, g, r;
        int n = 0, bc = 0;
        b = 8'($urandom); g = 8'($urandom); r = 8'($urandom);
        q3.delete(); viol3 = 0; badrun3 = 0;
        @(negedge clk);
        if3.type_input = 2'd1; if3.blue_input = b; if3.green_input = g; if3.red_input = r;
        if3.doled_start = 1'b1;
        while (!if3.doled_busy && n < 20) begin @(negedge clk); n++; end
        if3.doled_start = 1'b0;
        if3.blue_input = ~b;
        while (if3.doled_busy && bc < 2000) begin bc++; @(negedge clk); end
        checks += 5;
        if (pack_bits(q3) !== model_frame(2'd1, b, g, r)) begin
            failures++; $display("FAIL div3_bits got %h want %h", pack_bits(q3), model_frame(2'd1, b, g, r));
        end
        if (bc != 192)        begin failures++; $display("FAIL div3_busy_cycles got %0d want 192", bc); end
        if (q3.size() != 32)  begin failures++; $display("FAIL div3_edges got %0d want 32", q3.size()); end
        if (viol3 != 0)       begin failures++; $display("FAIL div3_mosi_stable got %0d changes want 0", viol3); end
        if (badrun3 != 0)     begin failures++; $display("FAIL div3_phase_len got %0d bad phases want 0", badrun3); end
    endtask

    task automatic test_reset_midframe;
        int n = 0, busy_seen = 0;
        q1.delete();
        @(negedge clk);
        if1.type_input = 2'd1; if1.blue_input = 8'hFF; if1.green_input = 8'hFF; if1.red_input = 8'hFF;
        if1.doled_start = 1'b1;
        while (q1.size() < 10 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (q1.size() < 10) begin failures++; $display("FAIL rst_mid_reach got %0d bits want 10", q1.size()); end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (if1.doled_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got %b want 0", if1.doled_busy); end
        if (sck1 !== 1'b0)           begin failures++; $display("FAIL rst_mid_sck got %b want 0", sck1); end
        if (mosi1 !== 1'b0)          begin failures++; $display("FAIL rst_mid_mosi got %b want 0", mosi1); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q1.delete();
        repeat (60) begin
            @(negedge clk);
            if (if1.doled_busy) busy_seen++;
        end
        checks += 2;
        if (busy_seen != 0)  begin failures++; $display("FAIL rst_mid_no_resume got busy %0d cycles want 0", busy_seen); end
        if (q1.size() != 0)  begin failures++; $display("FAIL rst_mid_no_sck got %0d edges want 0", q1.size()); end
        if1.doled_start = 1'b0;
        @(negedge clk);
        if1.doled_start = 1'b1;
        n = 0;
        while (!if1.doled_busy && n < 20) begin @(negedge clk); n++; end
        if1.doled_start = 1'b0;
        n = 0;
        while (if1.doled_busy && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (pack_bits(q1) !== 32'hFFFF_FFFF || q1.size() != 32) begin
            failures++; $display("FAIL rst_mid_fresh_frame got %h (%0d bits) want ffffffff (32 bits)", pack_bits(q1), q1.size());
        end
    endtask

    initial begin
        if1.type_input = 2'd0; if1.blue_input = 8'd0; if1.green_input = 8'd0; if1.red_input = 8'd0;
        if1.doled_start = 1'b0;
        if3.type_input = 2'd0; if3.blue_input = 8'd0; if3.green_input = 8'd0; if3.red_input = 8'd0;
        if3.doled_start = 1'b0;
        test_reset;
        test_led_basic;
        test_start_end;
        test_back_to_back;
        test_start_during_busy;
        test_held_start;
        test_div3;
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
